// File: rtl/fl_trans_gen_pkg.sv
// rtl/fl_trans_gen_pkg.sv - shared types, header layout and REM helper for fl_trans_gen
package fl_trans_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  localparam int HDR_STREAM_BYTE = 0;
  localparam int HDR_ID_LO_BYTE  = 1;
  localparam int HDR_ID_HI_BYTE  = 2;
  localparam int HDR_LAST_BYTE   = 3;

  // b is always a power of two, so the modulo reduces to a mask
  function automatic logic [11:0] rem_of(input logic [11:0] len, input int unsigned b);
    rem_of = (len - 12'd1) & 12'(b - 1);
  endfunction

endpackage

// File: rtl/fl_trans_gen_pattern.sv
// rtl/fl_trans_gen_pattern.sv - combinational header/payload word builder
module fl_trans_gen_pattern
  import fl_trans_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [15:0]           data_id_i,
  input  logic [7:0]            stream_id_i,
  input  logic [7:0]            offset_i,
  input  logic [11:0]           valid_i,
  input  logic                  hdr_sel_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (hdr_sel_i) begin
        if (i == HDR_STREAM_BYTE)     data_o[i*8 +: 8] = stream_id_i;
        else if (i == HDR_ID_LO_BYTE) data_o[i*8 +: 8] = data_id_i[7:0];
        else if (i == HDR_ID_HI_BYTE) data_o[i*8 +: 8] = data_id_i[15:8];
      end else if (12'(i) < valid_i) begin
        // only the low byte of the offset matters: the pattern is mod 256
        data_o[i*8 +: 8] = data_id_i[7:0] + offset_i + 8'(i);
      end
    end
  end

endmodule

// File: rtl/fl_trans_gen.sv
// rtl/fl_trans_gen.sv - FrameLink transaction generator top: FSM, counters, output registers
module fl_trans_gen
  import fl_trans_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              START,
  input  logic [7:0]                        STREAM_ID,
  input  logic [15:0]                       FRAME_COUNT,
  input  logic                              HDR_EN,
  input  logic [11:0]                       PAYLOAD_LEN,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [$clog2(DATA_WIDTH/8)-1:0]   TX_REM,
  output logic                              TX_SOF_N,
  output logic                              TX_EOF_N,
  output logic                              TX_SOP_N,
  output logic                              TX_EOP_N,
  output logic                              TX_SRC_RDY_N,
  input  logic                              TX_DST_RDY_N,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR,
  output logic [15:0]                       FRAMES_SENT
);

  localparam int          B   = DATA_WIDTH / 8;
  localparam int          RW  = $clog2(B);
  localparam logic [11:0] B12 = 12'(B);

  state_e          state_q, state_d;
  logic [11:0]     len_q, off_q, off_d;
  logic [15:0]     cnt_q, id_q, id_d, frames_q, frames_d;
  logic [7:0]      sid_q;
  logic            hdr_en_q;
  logic            busy_q, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q, pat_data;
  logic [RW-1:0]   rem_q, n_rem;
  logic            sof_q, sop_q, eop_q, eof_q, src_q;
  logic            n_sof, n_sop, n_eop, n_eof;
  logic            xfer, cur_last, load;
  logic [11:0]     n_len, rem_bytes, n_valid;
  logic            n_hdr_en, n_last, n_hdr;
  logic [7:0]      n_sid;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    off_d    = off_q;
    frames_d = frames_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    xfer     = !src_q && !TX_DST_RDY_N;
    cur_last = (len_q - off_q) <= B12;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (PAYLOAD_LEN == 12'd0) err_d = 1'b1;
          else if (FRAME_COUNT == 16'd0) done_d = 1'b1;
          else begin
            state_d  = HDR_EN ? ST_HDR : ST_PAY;
            id_d     = '0;
            off_d    = '0;
            frames_d = '0;
            load     = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d = ST_PAY;
          off_d   = '0;
          load    = 1'b1;
        end
      end
      ST_PAY: begin
        if (xfer) begin
          load = 1'b1;
          if (cur_last) begin
            frames_d = frames_q + 16'd1;
            id_d     = id_q + 16'd1;
            off_d    = '0;
            if (frames_d == cnt_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = hdr_en_q ? ST_HDR : ST_PAY;
            end
          end else begin
            off_d = off_q + B12;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The next word is built from live inputs when launching, latched config otherwise
    n_len     = (state_q == ST_IDLE) ? PAYLOAD_LEN : len_q;
    n_hdr_en  = (state_q == ST_IDLE) ? HDR_EN : hdr_en_q;
    n_sid     = (state_q == ST_IDLE) ? STREAM_ID : sid_q;
    n_hdr     = (state_d == ST_HDR);
    rem_bytes = n_len - off_d;
    n_last    = rem_bytes <= B12;
    n_valid   = n_last ? rem_bytes : B12;
    n_rem     = n_hdr ? RW'(HDR_LAST_BYTE) : (n_last ? RW'(rem_of(n_len, B)) : RW'(B - 1));
    n_sof     = n_hdr ? 1'b0 : !((off_d == 12'd0) && !n_hdr_en);
    n_sop     = n_hdr ? 1'b0 : !(off_d == 12'd0);
    n_eop     = n_hdr ? 1'b0 : !n_last;
    n_eof     = n_hdr ? 1'b1 : !n_last;
  end

  fl_trans_gen_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .data_id_i   (id_d),
    .stream_id_i (n_sid),
    .offset_i    (off_d[7:0]),
    .valid_i     (n_valid),
    .hdr_sel_i   (n_hdr),
    .data_o      (pat_data)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      sid_q    <= '0;
      hdr_en_q <= 1'b0;
      id_q     <= '0;
      off_q    <= '0;
      frames_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      rem_q    <= '0;
      sof_q    <= 1'b1;
      sop_q    <= 1'b1;
      eop_q    <= 1'b1;
      eof_q    <= 1'b1;
      src_q    <= 1'b1;
    end else begin
      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        len_q    <= PAYLOAD_LEN;
        cnt_q    <= FRAME_COUNT;
        sid_q    <= STREAM_ID;
        hdr_en_q <= HDR_EN;
      end
      state_q  <= state_d;
      id_q     <= id_d;
      off_q    <= off_d;
      frames_q <= frames_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
      if (load && state_d != ST_IDLE) begin
        data_q <= pat_data;
        rem_q  <= n_rem;
        sof_q  <= n_sof;
        sop_q  <= n_sop;
        eop_q  <= n_eop;
        eof_q  <= n_eof;
        src_q  <= 1'b0;
      end else if (load) begin
        sof_q <= 1'b1;
        sop_q <= 1'b1;
        eop_q <= 1'b1;
        eof_q <= 1'b1;
        src_q <= 1'b1;
      end
    end
  end

  assign TX_DATA      = data_q;
  assign TX_REM       = rem_q;
  assign TX_SOF_N     = sof_q;
  assign TX_SOP_N     = sop_q;
  assign TX_EOP_N     = eop_q;
  assign TX_EOF_N     = eof_q;
  assign TX_SRC_RDY_N = src_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign FRAMES_SENT  = frames_q;

endmodule

// File: tb/tb_fl_trans_gen.sv
// tb/tb_fl_trans_gen.sv - directed self-checking bench for fl_trans_gen (DATA_WIDTH=32)
module tb_fl_trans_gen;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [7:0]  STREAM_ID;
  logic [15:0] FRAME_COUNT;
  logic        HDR_EN;
  logic [11:0] PAYLOAD_LEN;
  logic [31:0] TX_DATA;
  logic [1:0]  TX_REM;
  logic        TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N;
  logic        TX_DST_RDY_N;
  logic        BUSY, DONE, ERR;
  logic [15:0] FRAMES_SENT;

  int vectors = 0;
  int miscompares = 0;

  fl_trans_gen #(.DATA_WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .STREAM_ID(STREAM_ID),
    .FRAME_COUNT(FRAME_COUNT), .HDR_EN(HDR_EN), .PAYLOAD_LEN(PAYLOAD_LEN),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N), .TX_SRC_RDY_N(TX_SRC_RDY_N),
    .TX_DST_RDY_N(TX_DST_RDY_N), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .FRAMES_SENT(FRAMES_SENT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags are the active-low pin values: {sof_n, sop_n, eop_n, eof_n}
  task automatic chk_word(input string tag, input logic [31:0] data, input logic [1:0] rem,
                          input logic [3:0] flags);
    chk(tag, {25'd0, TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N},
        {25'd0, data, rem, flags, 1'b0});
  endtask

  task automatic chk_end(input string tag, input logic [15:0] frames);
    chk(tag, {44'd0, BUSY, DONE, TX_SRC_RDY_N, FRAMES_SENT}, {44'd0, 1'b0, 1'b1, 1'b1, frames});
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {6'd0, TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N, TX_SRC_RDY_N,
              BUSY, DONE, ERR, FRAMES_SENT},
        {6'd0, 32'd0, 2'd0, 5'b11111, 3'b000, 16'd0});
  endtask

  task automatic start_cmd(input logic hdr, input logic [7:0] sid, input logic [11:0] len,
                           input logic [15:0] cnt);
    HDR_EN = hdr; STREAM_ID = sid; PAYLOAD_LEN = len; FRAME_COUNT = cnt;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; STREAM_ID = '0; FRAME_COUNT = '0; HDR_EN = 1'b0;
    PAYLOAD_LEN = '0; TX_DST_RDY_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset("reset_values");
    RESET_N = 1'b1;
    @(negedge CLK);

    // header + 6-byte payload, sink always ready
    start_cmd(1'b1, 8'h05, 12'd6, 16'd1);
    chk("busy_after_start", {63'd0, BUSY}, 64'd1);
    chk_word("t1_hdr", 32'h0000_0005, 2'd3, 4'b0001);
    @(negedge CLK);
    chk_word("t1_pay0", 32'h0302_0100, 2'd3, 4'b1011);
    @(negedge CLK);
    chk_word("t1_pay1", 32'h0000_0504, 2'd1, 4'b1100);
    @(negedge CLK);
    chk_end("t1_done", 16'd1);

    // same command with three stall cycles on the first payload word
    start_cmd(1'b1, 8'h05, 12'd6, 16'd1);
    chk_word("t2_hdr", 32'h0000_0005, 2'd3, 4'b0001);
    @(negedge CLK);
    TX_DST_RDY_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_word($sformatf("t2_stall%0d", i), 32'h0302_0100, 2'd3, 4'b1011);
    end
    TX_DST_RDY_N = 1'b0;
    @(negedge CLK);
    chk_word("t2_pay1", 32'h0000_0504, 2'd1, 4'b1100);
    @(negedge CLK);
    chk_end("t2_done", 16'd1);

    // three back-to-back single-word frames without header
    start_cmd(1'b0, 8'h00, 12'd4, 16'd3);
    chk_word("t3_f0", 32'h0302_0100, 2'd3, 4'b0000);
    @(negedge CLK);
    chk_word("t3_f1", 32'h0403_0201, 2'd3, 4'b0000);
    @(negedge CLK);
    chk_word("t3_f2", 32'h0504_0302, 2'd3, 4'b0000);
    @(negedge CLK);
    chk_end("t3_done", 16'd3);

    // degenerate commands
    start_cmd(1'b0, 8'h00, 12'd4, 16'd0);
    chk("t4_cnt0_done", {61'd0, BUSY, DONE, TX_SRC_RDY_N}, {61'd0, 3'b011});
    @(negedge CLK);
    chk("t4_cnt0_quiet", {61'd0, BUSY, DONE, TX_SRC_RDY_N}, {61'd0, 3'b001});
    start_cmd(1'b0, 8'h00, 12'd0, 16'd2);
    chk("t4_len0_err", {61'd0, BUSY, ERR, TX_SRC_RDY_N}, {61'd0, 3'b011});
    @(negedge CLK);
    chk("t4_len0_quiet", {61'd0, BUSY, ERR, TX_SRC_RDY_N}, {61'd0, 3'b001});

    // START while busy is ignored
    start_cmd(1'b0, 8'h00, 12'd4, 16'd2);
    chk_word("t5_f0", 32'h0302_0100, 2'd3, 4'b0000);
    FRAME_COUNT = 16'd5; PAYLOAD_LEN = 12'd8; HDR_EN = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk_word("t5_f1", 32'h0403_0201, 2'd3, 4'b0000);
    @(negedge CLK);
    chk_end("t5_done", 16'd2);
    @(negedge CLK);
    chk("t5_stays_idle", {62'd0, BUSY, TX_SRC_RDY_N}, {62'd0, 2'b01});

    // asynchronous reset during the second payload word
    start_cmd(1'b1, 8'h22, 12'd12, 16'd1);
    chk_word("t6_hdr", 32'h0000_0022, 2'd3, 4'b0001);
    @(negedge CLK);
    chk_word("t6_pay0", 32'h0302_0100, 2'd3, 4'b1011);
    @(negedge CLK);
    chk_word("t6_pay1", 32'h0706_0504, 2'd3, 4'b1111);
    #2 RESET_N = 1'b0;
    #1 chk_reset("t6_async_reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("t6_no_traffic%0d", i), {62'd0, BUSY, TX_SRC_RDY_N}, {62'd0, 2'b01});
    end
    start_cmd(1'b0, 8'h00, 12'd2, 16'd1);
    chk_word("t6_restart", 32'h0000_0100, 2'd1, 4'b0000);
    @(negedge CLK);
    chk_end("t6_restart_done", 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
